// File: rtl/fetch_unit_dual.sv
// Dual-issue fetch stage and F/D pipeline latch feeding the dual-slot decoder.
// Latency: the pair fetched at PC is presented on fd_* one cycle later; a redirect costs one nop-pair bubble.
// Backpressure: stall holds PC and the F/D latch; ex_redirect overrides stall, and dec_redirect is ignored while stalled.
//
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   stall                         - decode hazard; freeze PC and F/D latch
//   ex_redirect / ex_target       - execute-stage correction (highest priority after reset)
//   dec_redirect / dec_target     - decoder predicted-taken redirect from the top slot
//   imem_addr_* / imem_q_*        - combinational instruction-memory read of the pair (PC, PC+1)
//   fd_instr_*, fd_pc_*, fd_valid_* - F/D latch contents for the top and bot slots
//   kill_bot                      - bot slot currently in decode is wrong-path
//   redirect_count                - saturating count of accepted redirects
module fetch_unit_dual #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] NOP    = 32'h00000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_target,
  input  logic              dec_redirect,
  input  logic [31:0]       dec_target,
  input  logic [31:0]       imem_q_top,
  input  logic [31:0]       imem_q_bot,
  output logic [ADDR_W-1:0] imem_addr_top,
  output logic [ADDR_W-1:0] imem_addr_bot,
  output logic [31:0]       fd_instr_top,
  output logic [31:0]       fd_instr_bot,
  output logic [31:0]       fd_pc_top,
  output logic [31:0]       fd_pc_bot,
  output logic              fd_valid_top,
  output logic              fd_valid_bot,
  output logic              kill_bot,
  output logic [15:0]       redirect_count
);

  logic [31:0] pc;
  logic [31:0] pcPlusOne;
  logic [31:0] pcPlusTwo;
  logic [31:0] exTargetPlusOne;
  logic [31:0] decTargetPlusOne;
  logic [15:0] countNext;

  // All PC arithmetic wraps naturally at 2^32; memory addresses wrap at 2^ADDR_W by truncation.
  assign pcPlusOne        = pc + 32'd1;
  assign pcPlusTwo        = pc + 32'd2;
  assign exTargetPlusOne  = ex_target + 32'd1;
  assign decTargetPlusOne = dec_target + 32'd1;

  assign imem_addr_top = pc[ADDR_W-1:0];
  assign imem_addr_bot = pcPlusOne[ADDR_W-1:0];

  // Saturating increment: the counter sticks at all-ones.
  assign countNext = (redirect_count == 16'hFFFF) ? redirect_count : redirect_count + 16'd1;

  // The decoder's top-slot redirect only makes the bot slot wrong-path when it is actually
  // accepted this cycle: a stalled decoder re-asserts it later, and an execute redirect
  // flushes everything anyway.
  assign kill_bot = dec_redirect & fd_valid_top & ~stall & ~ex_redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= 32'd0;
      fd_instr_top   <= NOP;
      fd_instr_bot   <= NOP;
      fd_pc_top      <= 32'd0;
      fd_pc_bot      <= 32'd1;
      fd_valid_top   <= 1'b0;
      fd_valid_bot   <= 1'b0;
      redirect_count <= 16'd0;
    end else if (ex_redirect) begin
      pc             <= ex_target;
      fd_instr_top   <= NOP;
      fd_instr_bot   <= NOP;
      fd_pc_top      <= ex_target;
      fd_pc_bot      <= exTargetPlusOne;
      fd_valid_top   <= 1'b0;
      fd_valid_bot   <= 1'b0;
      redirect_count <= countNext;
    end else if (stall) begin
      // Hold everything; any dec_redirect will be re-presented once the stall clears.
      pc             <= pc;
    end else if (dec_redirect) begin
      // The pair fetched this cycle follows the wrong path, so latch a bubble instead.
      pc             <= dec_target;
      fd_instr_top   <= NOP;
      fd_instr_bot   <= NOP;
      fd_pc_top      <= dec_target;
      fd_pc_bot      <= decTargetPlusOne;
      fd_valid_top   <= 1'b0;
      fd_valid_bot   <= 1'b0;
      redirect_count <= countNext;
    end else begin
      pc             <= pcPlusTwo;
      fd_instr_top   <= imem_q_top;
      fd_instr_bot   <= imem_q_bot;
      fd_pc_top      <= pc;
      fd_pc_bot      <= pcPlusOne;
      fd_valid_top   <= 1'b1;
      fd_valid_bot   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit_dual.sv
// Directed bench for fetch_unit_dual: reset, streaming, stall, redirects, wrap and counter saturation.
// Latency: checks are taken 1 time unit after each rising edge, inputs change at the same point.
// Backpressure: stall is driven directly from the stimulus sequence.
module tb_fetch_unit_dual;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              stall;
  logic              ex_redirect;
  logic [31:0]       ex_target;
  logic              dec_redirect;
  logic [31:0]       dec_target;
  logic [31:0]       imem_q_top;
  logic [31:0]       imem_q_bot;
  logic [ADDR_W-1:0] imem_addr_top;
  logic [ADDR_W-1:0] imem_addr_bot;
  logic [31:0]       fd_instr_top;
  logic [31:0]       fd_instr_bot;
  logic [31:0]       fd_pc_top;
  logic [31:0]       fd_pc_bot;
  logic              fd_valid_top;
  logic              fd_valid_bot;
  logic              kill_bot;
  logic [15:0]       redirect_count;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clock = ~clock;

  // Memory model: each word is tagged with its own address.
  function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE0000 | {20'd0, a};
  endfunction

  assign imem_q_top = word(imem_addr_top);
  assign imem_q_bot = word(imem_addr_bot);

  fetch_unit_dual #(.ADDR_W(ADDR_W), .NOP(32'h00000000)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .dec_redirect  (dec_redirect),
    .dec_target    (dec_target),
    .imem_q_top    (imem_q_top),
    .imem_q_bot    (imem_q_bot),
    .imem_addr_top (imem_addr_top),
    .imem_addr_bot (imem_addr_bot),
    .fd_instr_top  (fd_instr_top),
    .fd_instr_bot  (fd_instr_bot),
    .fd_pc_top     (fd_pc_top),
    .fd_pc_bot     (fd_pc_bot),
    .fd_valid_top  (fd_valid_top),
    .fd_valid_bot  (fd_valid_bot),
    .kill_bot      (kill_bot),
    .redirect_count(redirect_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    dec_redirect = 1'b0; dec_target = '0;
    tick(); tick();

    // Reset state
    check("rst_valid_top", 32'(fd_valid_top), 32'd0);
    check("rst_valid_bot", 32'(fd_valid_bot), 32'd0);
    check("rst_pc_top", fd_pc_top, 32'd0);
    check("rst_pc_bot", fd_pc_bot, 32'd1);
    check("rst_instr_top", fd_instr_top, 32'd0);
    check("rst_count", 32'(redirect_count), 32'd0);
    check("rst_addr_top", 32'(imem_addr_top), 32'd0);
    check("rst_addr_bot", 32'(imem_addr_bot), 32'd1);

    // Free-run
    reset = 1'b0;
    tick();
    check("run0_pc_top", fd_pc_top, 32'd0);
    check("run0_instr_top", fd_instr_top, 32'hC0DE0000);
    check("run0_instr_bot", fd_instr_bot, 32'hC0DE0001);
    check("run0_valid_bot", 32'(fd_valid_bot), 32'd1);
    tick();
    check("run1_pc_top", fd_pc_top, 32'd2);
    check("run1_instr_top", fd_instr_top, 32'hC0DE0002);
    check("run1_pc_bot", fd_pc_bot, 32'd3);
    tick();
    check("run2_pc_top", fd_pc_top, 32'd4);
    check("run2_addr_top", 32'(imem_addr_top), 32'd6);

    // Stall for three cycles at PC=6
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc_top", fd_pc_top, 32'd4);
      check("stall_addr_top", 32'(imem_addr_top), 32'd6);
    end
    stall = 1'b0;
    tick();
    check("resume_pc_top", fd_pc_top, 32'd6);
    check("resume_instr_top", fd_instr_top, 32'hC0DE0006);
    tick();
    check("pre_dec_pc_top", fd_pc_top, 32'd8);

    // Decoder redirect to 0x41
    dec_redirect = 1'b1; dec_target = 32'h41;
    #1;
    check("dec_kill_bot", 32'(kill_bot), 32'd1);
    tick();
    dec_redirect = 1'b0;
    #1;
    check("dec_bubble_valid_top", 32'(fd_valid_top), 32'd0);
    check("dec_bubble_valid_bot", 32'(fd_valid_bot), 32'd0);
    check("dec_bubble_instr_top", fd_instr_top, 32'd0);
    check("dec_bubble_instr_bot", fd_instr_bot, 32'd0);
    check("dec_bubble_kill_bot", 32'(kill_bot), 32'd0);
    check("dec_addr_top", 32'(imem_addr_top), 32'h41);
    check("dec_count", 32'(redirect_count), 32'd1);
    tick();
    check("dec_after_pc_top", fd_pc_top, 32'h41);
    check("dec_after_pc_bot", fd_pc_bot, 32'h42);
    check("dec_after_instr_bot", fd_instr_bot, 32'hC0DE0042);
    check("dec_after_valid_top", 32'(fd_valid_top), 32'd1);
    check("dec_after_count", 32'(redirect_count), 32'd1);

    // ex_redirect, stall and dec_redirect together: execute wins, counted once
    ex_redirect = 1'b1; ex_target = 32'h100;
    stall = 1'b1; dec_redirect = 1'b1; dec_target = 32'h20;
    #1;
    check("combo_kill_bot", 32'(kill_bot), 32'd0);
    tick();
    ex_redirect = 1'b0; stall = 1'b0; dec_redirect = 1'b0;
    check("combo_addr_top", 32'(imem_addr_top), 32'h100);
    check("combo_valid_top", 32'(fd_valid_top), 32'd0);
    check("combo_instr_top", fd_instr_top, 32'd0);
    check("combo_pc_top", fd_pc_top, 32'h100);
    check("combo_count", 32'(redirect_count), 32'd2);
    tick();
    check("combo_after_pc_top", fd_pc_top, 32'h100);
    check("combo_after_valid", 32'(fd_valid_bot), 32'd1);

    // dec_redirect while stalled is ignored and not counted
    stall = 1'b1; dec_redirect = 1'b1; dec_target = 32'h20;
    #1;
    check("stalldec_kill_bot", 32'(kill_bot), 32'd0);
    tick();
    stall = 1'b0; dec_redirect = 1'b0;
    check("stalldec_count", 32'(redirect_count), 32'd2);
    check("stalldec_addr_top", 32'(imem_addr_top), 32'h102);
    check("stalldec_pc_top", fd_pc_top, 32'h100);

    // 32-bit wrap
    ex_redirect = 1'b1; ex_target = 32'hFFFFFFFE;
    tick();
    ex_redirect = 1'b0;
    check("wrap_count", 32'(redirect_count), 32'd3);
    check("wrap_addr_top", 32'(imem_addr_top), 32'hFFE);
    check("wrap_addr_bot", 32'(imem_addr_bot), 32'hFFF);
    tick();
    check("wrap_pc_top", fd_pc_top, 32'hFFFFFFFE);
    check("wrap_pc_bot", fd_pc_bot, 32'hFFFFFFFF);
    check("wrap_next_addr_top", 32'(imem_addr_top), 32'd0);
    check("wrap_next_addr_bot", 32'(imem_addr_bot), 32'd1);

    // Odd target at the top of the address space: imem address wraps at 2^ADDR_W
    ex_redirect = 1'b1; ex_target = 32'h00000FFF;
    tick();
    ex_redirect = 1'b0;
    check("odd_addr_top", 32'(imem_addr_top), 32'hFFF);
    check("odd_addr_bot", 32'(imem_addr_bot), 32'h000);
    check("odd_count", 32'(redirect_count), 32'd4);
    tick();
    check("odd_pc_top", fd_pc_top, 32'hFFF);
    check("odd_pc_bot", fd_pc_bot, 32'h1000);
    check("odd_instr_top", fd_instr_top, 32'hC0DE0FFF);
    check("odd_instr_bot", fd_instr_bot, 32'hC0DE0000);

    // Reset wins over a simultaneous execute redirect
    reset = 1'b1; ex_redirect = 1'b1; ex_target = 32'h55;
    tick();
    reset = 1'b0;
    check("rstex_addr_top", 32'(imem_addr_top), 32'd0);
    check("rstex_valid_top", 32'(fd_valid_top), 32'd0);
    check("rstex_pc_bot", fd_pc_bot, 32'd1);
    check("rstex_count", 32'(redirect_count), 32'd0);

    // Counter saturation over 65540 consecutive redirects
    for (int i = 0; i < 65534; i++) begin
      ex_target = 32'(i);
      tick();
    end
    check("sat_count_fffe", 32'(redirect_count), 32'hFFFE);
    tick();
    check("sat_count_ffff", 32'(redirect_count), 32'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    check("sat_count_hold", 32'(redirect_count), 32'hFFFF);
    ex_redirect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
